// File: rtl/kbd_scan_ctrl_if.sv
// ============================================================
// kbd_scan_ctrl_if : key-event read bus between controller and CPU
// Rev 1.0
// ============================================================
`default_nettype none

interface kbd_scan_ctrl_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          rd_en;
  logic          ovf_clr;
  logic          key_valid;
  logic [7:0]    key_code;
  logic          key_ext;
  logic          key_break;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  modport master (
    output rd_en, ovf_clr,
    input  key_valid, key_code, key_ext, key_break, fifo_count, overflow
  );

  modport slave (
    input  rd_en, ovf_clr,
    output key_valid, key_code, key_ext, key_break, fifo_count, overflow
  );
endinterface

`default_nettype wire

// File: rtl/kbd_scan_ctrl.sv
// ============================================================
// kbd_scan_ctrl : PS/2 byte capture, set-2 prefix decode, event FIFO
// Rev 1.0
// ============================================================
`default_nettype none

module kbd_scan_ctrl #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           kbd_rda,
  input  logic [7:0]     kbd_byte,
  output logic           kbd_clear,
  kbd_scan_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    DROP = 2'd2
  } state_t;

  // synchronizer and edge detect
  logic sync1_q, rda_s_q, rda_d_q;
  logic primed_q, primed_d;
  logic armed_q, armed_d;
  logic rise;

  state_t        state_q, state_d;
  logic [7:0]    byte_q, byte_d;
  logic          pend_ext_q, pend_ext_d;
  logic          pend_brk_q, pend_brk_d;
  logic [2:0]    skip_q, skip_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic          push;
  logic [9:0]    push_data;

  logic [9:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          full, not_empty, pop, wr_en;
  logic [9:0]    head;

  // A receiver flag still high when reset releases must be seen low before
  // a rising edge counts; primed_q marks that sync1_q holds a real sample.
  always_comb begin
    primed_d = 1'b1;
    armed_d  = armed_q | (primed_q & ~sync1_q);
    rise     = rda_s_q & ~rda_d_q & armed_q;
  end

  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    pend_ext_d = pend_ext_q;
    pend_brk_d = pend_brk_q;
    skip_d     = skip_q;
    tmo_d      = tmo_q;
    push       = 1'b0;
    push_data  = 10'h000;

    case (state_q)
      IDLE: begin
        if (rise) begin
          byte_d  = kbd_byte;
          tmo_d   = '0;
          state_d = ACK;
        end else if (pend_ext_q || pend_brk_q) begin
          if (tmo_q == TMO_LAST) begin
            pend_ext_d = 1'b0;
            pend_brk_d = 1'b0;
            tmo_d      = '0;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
      end

      ACK: begin
        state_d = DROP;
        if (skip_q != 3'd0) begin
          skip_d = skip_q - 3'd1;
        end else begin
          case (byte_q)
            8'hE1: begin
              skip_d     = 3'd7;
              push       = 1'b1;
              push_data  = {2'b00, 8'hE1};
              pend_ext_d = 1'b0;
              pend_brk_d = 1'b0;
            end
            8'hE0: pend_ext_d = 1'b1;
            8'hF0: pend_brk_d = 1'b1;
            8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF: begin
              pend_ext_d = 1'b0;
              pend_brk_d = 1'b0;
            end
            default: begin
              push       = 1'b1;
              push_data  = {pend_ext_q, pend_brk_q, byte_q};
              pend_ext_d = 1'b0;
              pend_brk_d = 1'b0;
            end
          endcase
        end
      end

      DROP: begin
        if (!rda_s_q) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // A push into a full FIFO succeeds only when a pop frees a slot that cycle.
  always_comb begin
    not_empty  = (count_q != '0);
    full       = (count_q == FULL_COUNT);
    pop        = bus.rd_en & not_empty;
    wr_en      = push & (~full | pop);
    wr_ptr_d   = wr_ptr_q + AW'(wr_en);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + CW'(wr_en) - CW'(pop);
    overflow_d = overflow_q;
    if (bus.ovf_clr) overflow_d = 1'b0;
    if (push && full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      rda_s_q    <= 1'b0;
      rda_d_q    <= 1'b0;
      primed_q   <= 1'b0;
      armed_q    <= 1'b0;
      state_q    <= IDLE;
      byte_q     <= 8'h00;
      pend_ext_q <= 1'b0;
      pend_brk_q <= 1'b0;
      skip_q     <= 3'd0;
      tmo_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      sync1_q    <= kbd_rda;
      rda_s_q    <= sync1_q;
      rda_d_q    <= rda_s_q;
      primed_q   <= primed_d;
      armed_q    <= armed_d;
      state_q    <= state_d;
      byte_q     <= byte_d;
      pend_ext_q <= pend_ext_d;
      pend_brk_q <= pend_brk_d;
      skip_q     <= skip_d;
      tmo_q      <= tmo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[wr_ptr_q] <= push_data;
  end

  // Head fields read as zero while empty so stale entries never show.
  assign head           = mem_q[rd_ptr_q];
  assign kbd_clear      = (state_q == ACK);
  assign bus.key_valid  = not_empty;
  assign bus.key_code   = not_empty ? head[7:0] : 8'h00;
  assign bus.key_ext    = not_empty & head[9];
  assign bus.key_break  = not_empty & head[8];
  assign bus.fifo_count = count_q;
  assign bus.overflow   = overflow_q;
endmodule

`default_nettype wire

// File: doc/kbd_scan_ctrl.md
# kbd_scan_ctrl

Sequencing controller for the PS/2 keyboard receiver. It synchronizes the receiver's `rda` flag into the system clock domain and captures each received byte. It acknowledges the byte by pulsing the receiver's `clear` input, then decodes PS/2 set-2 prefixes (E0 extended, F0 break, E1 pause sequence) into complete key events. Events are queued in a small FIFO read by the CPU/peripheral bus.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2 to 64.
- `TIMEOUT`, 50000: clk cycles after which a pending prefix is abandoned (1 ms at 50 MHz).
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high. Clock `clk`.
- `kbd_rda` in 1: receiver byte-ready; asynchronous (PS/2 clock domain).
- `kbd_byte` in 8: receiver data; stable while `kbd_rda` is high.
- `kbd_clear` out 1: one-cycle acknowledge pulse to the receiver's `clear` input.
- `rd_en` in 1: pop the head event; ignored when `key_valid` is 0.
- `key_valid` out 1: FIFO non-empty.
- `key_code` out 8: head event scan code (first-word fall-through).
- `key_ext` out 1: head event had an E0 prefix.
- `key_break` out 1: head event is a key release (F0 prefix).
- `fifo_count` out clog2(DEPTH)+1: number of occupied entries.
- `overflow` out 1: sticky; an event was dropped because the FIFO was full.
- `ovf_clr` in 1: clears `overflow`.

## Operation
- Reset values: `kbd_clear`=0, `key_valid`=0, `key_code`=0, `key_ext`=0, `key_break`=0, `fifo_count`=0, `overflow`=0. All internal state is also reset: FSM IDLE, prefix flags 0, skip counter 0, timeout counter 0, synchronizer flops 0.
- `kbd_rda` passes through a 2-flop synchronizer (`rda_s`) plus a delay flop for rising-edge detection.
- Capture FSM:
  - IDLE: on `rda_s` rising edge, latch `kbd_byte` into `byte_r` and go to ACK.
  - ACK: `kbd_clear`=1 for exactly this cycle; decode `byte_r` (rules below); go to DROP.
  - DROP: wait until `rda_s`=0, then go to IDLE. A new rising edge is only recognized from IDLE.
- Decode rules, applied in ACK, in priority order:
  - Skip counter nonzero: decrement it; discard the byte.
  - 0xE1: skip counter=7; emit event {ext=0, brk=0, code=0xE1}; clear the prefix flags.
  - 0xE0: set `pend_ext`.
  - 0xF0: set `pend_brk`.
  - 0x00, 0xAA, 0xFA, 0xFE, 0xFF: discard; clear both prefix flags.
  - Any other byte: emit event {`pend_ext`, `pend_brk`, byte}; clear both prefix flags.
- Timeout: the counter runs while either prefix flag is set and the FSM is in IDLE. It reloads on every capture. On reaching TIMEOUT it clears both prefix flags. It does not affect the skip counter.
- FIFO: 10-bit entries {ext, brk, code}. Push happens on the cycle after ACK.
  - Push while full and no pop that cycle: the event is dropped and `overflow` is set.
  - Push and pop in the same cycle while full: both succeed; count unchanged.
  - Pop while empty: ignored.
  - Read and write pointers wrap modulo DEPTH.
- `overflow`: a same-cycle set takes priority over `ovf_clr`.

## Timing
- Edge E0 samples `kbd_rda`=1.
- E1: `rda_s`=1.
- E2: `byte_r` latched; FSM enters ACK; `kbd_clear` is high for cycle E2 to E3.
- E3: event pushed. When the FIFO was previously empty, `key_valid`, `key_code` and flags are valid after E3.
- Latency from `kbd_rda` rise to visible event: 4 clk edges. The FSM occupies at least 4 cycles per byte, far shorter than a PS/2 byte (~1 ms).
- `rd_en` sampled high with `key_valid`=1 at edge E: head advances, and new head / `fifo_count` are visible after E.
- `rst` mid-byte: all state is discarded. A `kbd_rda` that is still high after reset is released produces a rising edge only after first being seen low; such a byte is not captured and is not acknowledged.
- `kbd_byte` is sampled only at the capture edge; its value at other times is ignored.

## Test plan
- Single make: `kbd_rda` rise with byte 0x1C → one-cycle `kbd_clear` exactly 2 edges after the sampling edge; `key_valid`=1 with code 0x1C, ext=0, brk=0; `rd_en` → `key_valid`=0, `fifo_count`=0.
- Extended break: bytes E0, F0, 0x74 → exactly one event {ext=1, brk=1, 0x74}; three `kbd_clear` pulses.
- Pause sequence: E1 14 77 E1 F0 14 F0 77 → exactly one event 0xE1; a following 0x1C yields {0,0,0x1C}.
- Overflow: 9 make codes with no reads (DEPTH=8) → `fifo_count`=8, `overflow`=1, head still holds the first code. Simultaneous push and `rd_en` while full → count stays 8. `ovf_clr` → `overflow`=0.
- Prefix timeout: F0, then idle for TIMEOUT+1 cycles, then 0x1C → event brk=0.
- Reset mid-sequence: E0, then `rst` for one cycle, then 0x1C → event ext=0. All outputs equal their reset values during and immediately after reset.
